bank_arbiter: RTL and testbench
===============================

// Module: bank_arbiter
// PURPOSE
//  Registered round-the-clock arbiter sharing one 128-bit data bank (bram64k, 1-cycle read) among three
//  requesters: IC (input controller), MVU and Ctrl. Fixed priority IC > MVU > Ctrl, with anti-starvation
//  aging for MVU/Ctrl and optional locked bursts. Sits between requesters and the bank's BRAM port.
// PARAMETERS
//  a        9    address width (512 x 128b words)
//  w        128  data width
//  MAXWAIT  8    cycles a waiting MVU/Ctrl request may be passed over before forced grant (>=1)
//  MAXBURST 4    max consecutive locked grants to one owner (1 = locking disabled)
// PORTS
//  clk          in   1  clock
//  rst          in   1  synchronous active-high reset
//  req_{ic,mvu,ctrl}    in   1  access request; hold with addr/we/wdata stable until gnt seen
//  lock_{ic,mvu,ctrl}   in   1  keep ownership next cycle (burst) if still requesting
//  we_{ic,mvu,ctrl}     in   1  1 = write, 0 = read
//  addr_{ic,mvu,ctrl}   in   a  word address
//  wdata_{ic,mvu,ctrl}  in   w  write data
//  gnt_{ic,mvu,ctrl}    out  1  registered; high = this port owns bank this cycle
//  rvalid_{ic,mvu,ctrl} out  1  registered; read data for this port valid on rdata this cycle
//  rdata        out  w  read data (bram_rdata passthrough)
//  bram_addr    out  a  to BRAM
//  bram_wdata   out  w  to BRAM
//  bram_we      out  1  to BRAM write enable
//  bram_rdata   in   w  from BRAM, valid 1 cycle after read address presented
// BEHAVIOUR
//  State: owner reg {NONE,IC,MVU,CTRL}; burst_cnt (clog2(MAXBURST)+1 b); wait_mvu, wait_ctrl (sat. at MAXWAIT).
//  gnt_x = (owner==X). At most one gnt high, ever. owner==NONE -> all gnt low, bram_we=0.
//  Access cycle: gnt_x & req_x. bram_addr/wdata muxed from owner's inputs; bram_we = gnt_x & req_x & we_x.
//   gnt_x with req_x low (request withdrawn): no access, bram_we=0, no rvalid.
//  Read: access with we_x=0 in cycle t -> rvalid_x high in t+1, rdata = mem[addr]. Writes never raise rvalid.
//  Next-owner decision at every edge, in order:
//   1 hold: owner!=NONE & req_owner & lock_owner & burst_cnt<MAXBURST-1 -> same owner, burst_cnt++.
//   2 starve: wait_mvu==MAXWAIT & req_mvu -> MVU; else wait_ctrl==MAXWAIT & req_ctrl -> CTRL.
//   3 priority: req_ic -> IC; else req_mvu -> MVU; else req_ctrl -> CTRL; else NONE.
//   Owner changes (or rule 2/3 picks) -> burst_cnt=0. Same owner re-picked by rule 3 -> burst_cnt=0.
//  wait_x (x=mvu,ctrl): cleared when x picked or req_x low; else +1 (saturating) when req_x and not picked.
//  Grant latency: request in cycle t with bank free and no higher claim -> gnt in t+1.
//  Worst-case MVU/Ctrl wait bounded: MAXWAIT + MAXBURST + 1 cycles (Ctrl may additionally yield one MVU starve).
//  Lock from non-requesting owner ignored; lock on burst limit -> normal re-arbitration (owner may win again).
//  Reset (sync, dominates): owner=NONE, all gnt=0, rvalid=0, burst_cnt=0, wait=0, bram_addr=0,
//   bram_we=0; any read in flight during reset edge -> rvalid suppressed. First grant earliest cycle after rst low.
//  No X on bram_addr/bram_wdata when NONE: drive 0.
// TESTING
//  1 rst high 2 cycles, all req high -> all gnt/rvalid/bram_we 0 during rst; gnt_ic=1 first cycle after.
//  2 req_ic=req_mvu=req_ctrl=1 from cycle 0, no lock, MAXWAIT=8 -> gnt_ic cycles 1-8, gnt_mvu cycle 9,
//    gnt_ctrl first at cycle 10 (wait_ctrl saturated), never two gnts together.
//  3 MVU write addr 0x1A5 data 0xDEAD..BEEF, then Ctrl read 0x1A5 -> rvalid_ctrl exactly 1 cycle after
//    its access cycle, rdata = written value, rvalid_mvu/ic stay 0.
//  4 MVU req+lock held, MAXBURST=4, IC req from cycle 2 -> gnt_mvu 4 consecutive cycles then gnt_ic.
//  5 IC drops req in its gnt cycle -> bram_we=0, no rvalid_ic; next edge re-arbitrates to MVU if requesting.
//  6 rst asserted mid-burst after a read issue -> next cycle all gnt 0, rvalid 0, counters 0; random
//    3-port stimulus 10k cycles vs reference model: one-hot gnt, wait bound met, data matches.

Source files
------------

// File: rtl/bank_arbiter_if.sv
// Signal bundle between the three bank requesters (IC, MVU, Ctrl), the arbiter and the BRAM port.
// slave = arbiter side; master = requesters plus the BRAM behind the arbiter.
interface bank_arbiter_if #(
  parameter int a = 9,
  parameter int w = 128
);
  logic         req_ic,    req_mvu,    req_ctrl;
  logic         lock_ic,   lock_mvu,   lock_ctrl;
  logic         we_ic,     we_mvu,     we_ctrl;
  logic [a-1:0] addr_ic,   addr_mvu,   addr_ctrl;
  logic [w-1:0] wdata_ic,  wdata_mvu,  wdata_ctrl;
  logic         gnt_ic,    gnt_mvu,    gnt_ctrl;
  logic         rvalid_ic, rvalid_mvu, rvalid_ctrl;
  logic [w-1:0] rdata;

  logic [a-1:0] bram_addr;
  logic [w-1:0] bram_wdata;
  logic         bram_we;
  logic [w-1:0] bram_rdata;

  modport slave (
    input  req_ic, req_mvu, req_ctrl,
    input  lock_ic, lock_mvu, lock_ctrl,
    input  we_ic, we_mvu, we_ctrl,
    input  addr_ic, addr_mvu, addr_ctrl,
    input  wdata_ic, wdata_mvu, wdata_ctrl,
    output gnt_ic, gnt_mvu, gnt_ctrl,
    output rvalid_ic, rvalid_mvu, rvalid_ctrl,
    output rdata,
    output bram_addr, bram_wdata, bram_we,
    input  bram_rdata
  );

  modport master (
    output req_ic, req_mvu, req_ctrl,
    output lock_ic, lock_mvu, lock_ctrl,
    output we_ic, we_mvu, we_ctrl,
    output addr_ic, addr_mvu, addr_ctrl,
    output wdata_ic, wdata_mvu, wdata_ctrl,
    input  gnt_ic, gnt_mvu, gnt_ctrl,
    input  rvalid_ic, rvalid_mvu, rvalid_ctrl,
    input  rdata,
    input  bram_addr, bram_wdata, bram_we,
    output bram_rdata
  );
endinterface

// File: rtl/bank_arbiter.sv
// Shares one BRAM bank among IC > MVU > Ctrl with aging and locked bursts; grant 1 cycle after request,
// read data 1 cycle after access. Requesters hold req/addr/we/wdata until they see their grant.
module bank_arbiter #(
  parameter int a        = 9,
  parameter int w        = 128,
  parameter int MAXWAIT  = 8,
  parameter int MAXBURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  bank_arbiter_if.slave bus
);

  localparam int BW = $clog2(MAXBURST) + 1;
  localparam int WW = $clog2(MAXWAIT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAXBURST - 1);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAXWAIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IC,
    OWN_MVU,
    OWN_CTRL
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [WW-1:0] wait_mvu_q, wait_mvu_d;
  logic [WW-1:0] wait_ctrl_q, wait_ctrl_d;
  logic [2:0]    rvalid_q, rvalid_d;

  logic          own_req;
  logic          own_lock;
  logic          own_we;
  logic [a-1:0]  own_addr;
  logic [w-1:0]  own_wdata;
  logic          access;
  logic          hold;

  // Current owner's request fields; everything reads as zero when the bank is free.
  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    unique case (owner_q)
      OWN_IC: begin
        own_req   = bus.req_ic;
        own_lock  = bus.lock_ic;
        own_we    = bus.we_ic;
        own_addr  = bus.addr_ic;
        own_wdata = bus.wdata_ic;
      end
      OWN_MVU: begin
        own_req   = bus.req_mvu;
        own_lock  = bus.lock_mvu;
        own_we    = bus.we_mvu;
        own_addr  = bus.addr_mvu;
        own_wdata = bus.wdata_mvu;
      end
      OWN_CTRL: begin
        own_req   = bus.req_ctrl;
        own_lock  = bus.lock_ctrl;
        own_we    = bus.we_ctrl;
        own_addr  = bus.addr_ctrl;
        own_wdata = bus.wdata_ctrl;
      end
      default: ;
    endcase
  end

  // Reset also blocks the access of the cycle in which it is asserted.
  assign access = own_req & ~rst;
  assign hold   = (owner_q != OWN_NONE) & own_req & own_lock & (burst_q < BURST_LAST);

  always_comb begin
    owner_d     = OWN_NONE;
    burst_d     = '0;
    wait_mvu_d  = '0;
    wait_ctrl_d = '0;
    rvalid_d    = '0;

    if (hold) begin
      owner_d = owner_q;
      burst_d = burst_q + 1'b1;
    end else if (wait_mvu_q == WAIT_SAT && bus.req_mvu) begin
      owner_d = OWN_MVU;
    end else if (wait_ctrl_q == WAIT_SAT && bus.req_ctrl) begin
      owner_d = OWN_CTRL;
    end else if (bus.req_ic) begin
      owner_d = OWN_IC;
    end else if (bus.req_mvu) begin
      owner_d = OWN_MVU;
    end else if (bus.req_ctrl) begin
      owner_d = OWN_CTRL;
    end

    if (bus.req_mvu && owner_d != OWN_MVU)
      wait_mvu_d = (wait_mvu_q == WAIT_SAT) ? wait_mvu_q : wait_mvu_q + 1'b1;
    if (bus.req_ctrl && owner_d != OWN_CTRL)
      wait_ctrl_d = (wait_ctrl_q == WAIT_SAT) ? wait_ctrl_q : wait_ctrl_q + 1'b1;

    rvalid_d[0] = access & ~own_we & (owner_q == OWN_IC);
    rvalid_d[1] = access & ~own_we & (owner_q == OWN_MVU);
    rvalid_d[2] = access & ~own_we & (owner_q == OWN_CTRL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      burst_q     <= '0;
      wait_mvu_q  <= '0;
      wait_ctrl_q <= '0;
      rvalid_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      wait_mvu_q  <= wait_mvu_d;
      wait_ctrl_q <= wait_ctrl_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign bus.gnt_ic      = (owner_q == OWN_IC);
  assign bus.gnt_mvu     = (owner_q == OWN_MVU);
  assign bus.gnt_ctrl    = (owner_q == OWN_CTRL);
  assign bus.rvalid_ic   = rvalid_q[0];
  assign bus.rvalid_mvu  = rvalid_q[1];
  assign bus.rvalid_ctrl = rvalid_q[2];
  assign bus.rdata       = bus.bram_rdata;

  assign bus.bram_we     = access & own_we;
  assign bus.bram_addr   = rst ? '0 : own_addr;
  assign bus.bram_wdata  = rst ? '0 : own_wdata;

endmodule

// File: tb/tb_bank_arbiter.sv
// Bench for bank_arbiter: directed scenarios with literal expectations, then random three-port traffic
// checked every cycle against a rule-level model of ownership, BRAM traffic and read data.
module tb_bank_arbiter;
  localparam int A          = 9;
  localparam int W          = 128;
  localparam int MAXWAIT    = 8;
  localparam int MAXBURST   = 4;
  localparam int MVU_BOUND  = MAXWAIT + MAXBURST + 1;
  localparam int CTRL_BOUND = MAXWAIT + 2 * MAXBURST + 1;
  localparam logic [W-1:0] DATA = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bank_arbiter_if #(.a(A), .w(W)) bus ();

  bank_arbiter #(.a(A), .w(W), .MAXWAIT(MAXWAIT), .MAXBURST(MAXBURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Requester drive, index 1 = IC, 2 = MVU, 3 = Ctrl
  logic         t_req  [1:3];
  logic         t_lock [1:3];
  logic         t_we   [1:3];
  logic [A-1:0] t_addr [1:3];
  logic [W-1:0] t_wd   [1:3];
  bit           served [1:3];

  assign bus.req_ic     = t_req[1];
  assign bus.req_mvu    = t_req[2];
  assign bus.req_ctrl   = t_req[3];
  assign bus.lock_ic    = t_lock[1];
  assign bus.lock_mvu   = t_lock[2];
  assign bus.lock_ctrl  = t_lock[3];
  assign bus.we_ic      = t_we[1];
  assign bus.we_mvu     = t_we[2];
  assign bus.we_ctrl    = t_we[3];
  assign bus.addr_ic    = t_addr[1];
  assign bus.addr_mvu   = t_addr[2];
  assign bus.addr_ctrl  = t_addr[3];
  assign bus.wdata_ic   = t_wd[1];
  assign bus.wdata_mvu  = t_wd[2];
  assign bus.wdata_ctrl = t_wd[3];

  logic [3:1] d_gnt, d_rv;
  assign d_gnt = {bus.gnt_ctrl, bus.gnt_mvu, bus.gnt_ic};
  assign d_rv  = {bus.rvalid_ctrl, bus.rvalid_mvu, bus.rvalid_ic};

  // BRAM behind the arbiter: one-cycle read latency
  logic [W-1:0] bram_mem [512];
  logic [W-1:0] bram_rd;
  assign bus.bram_rdata = bram_rd;
  always @(posedge clk) begin
    if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_wdata;
    bram_rd <= bram_mem[bus.bram_addr];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner 0 = free, else requester index
  int           m_owner, m_burst, m_rv, nxt;
  int           m_wait [2:3];
  logic [W-1:0] m_rdata;
  logic [W-1:0] ref_mem [512];
  bit           started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_burst = 0; m_rv = 0;
      m_wait[2] = 0; m_wait[3] = 0;
      started = 1;
    end else if (started) begin
      m_rv = 0;
      if (m_owner != 0 && t_req[m_owner]) begin
        if (t_we[m_owner]) ref_mem[t_addr[m_owner]] = t_wd[m_owner];
        else begin
          m_rv    = m_owner;
          m_rdata = ref_mem[t_addr[m_owner]];
        end
      end
      if (m_owner != 0 && t_req[m_owner] && t_lock[m_owner] && m_burst < MAXBURST - 1) begin
        nxt = m_owner;
        m_burst++;
      end else begin
        m_burst = 0;
        if (m_wait[2] == MAXWAIT && t_req[2])      nxt = 2;
        else if (m_wait[3] == MAXWAIT && t_req[3]) nxt = 3;
        else if (t_req[1])                         nxt = 1;
        else if (t_req[2])                         nxt = 2;
        else if (t_req[3])                         nxt = 3;
        else                                       nxt = 0;
      end
      for (int x = 2; x <= 3; x++) begin
        if (nxt == x || !t_req[x]) m_wait[x] = 0;
        else if (m_wait[x] < MAXWAIT) m_wait[x]++;
      end
      m_owner = nxt;
    end
  end

  // Every-cycle comparison plus service-time bound for MVU/Ctrl
  logic [3:1]   e_gnt, e_rv;
  logic         e_we;
  logic [A-1:0] e_addr;
  logic [W-1:0] e_wd;
  int           wcnt [2:3] = '{0, 0};

  always @(negedge clk) begin
    if (started) begin
      e_gnt = '0;
      if (m_owner != 0) e_gnt[m_owner] = 1'b1;
      e_rv = '0;
      if (m_rv != 0) e_rv[m_rv] = 1'b1;
      e_we   = !rst && m_owner != 0 && t_req[m_owner] && t_we[m_owner];
      e_addr = (rst || m_owner == 0) ? '0 : t_addr[m_owner];
      e_wd   = (rst || m_owner == 0) ? '0 : t_wd[m_owner];
      chk("gnt", d_gnt, e_gnt);
      chk("gnt_onehot", $countones(d_gnt) <= 1, 1);
      chk("rvalid", d_rv, e_rv);
      chk("bram_we", bus.bram_we, e_we);
      chk("bram_addr", bus.bram_addr, e_addr);
      chk("bram_wdata", bus.bram_wdata, e_wd);
      if (m_rv != 0) chk("rdata", bus.rdata, m_rdata);
      for (int x = 2; x <= 3; x++) begin
        if (rst || !t_req[x] || d_gnt[x]) begin
          if (!rst && d_gnt[x] && wcnt[x] > 0)
            chk(x == 2 ? "mvu_wait_bound" : "ctrl_wait_bound",
                wcnt[x] <= (x == 2 ? MVU_BOUND : CTRL_BOUND), 1);
          wcnt[x] = 0;
        end else begin
          wcnt[x]++;
          if (wcnt[x] == (x == 2 ? MVU_BOUND : CTRL_BOUND) + 1)
            chk(x == 2 ? "mvu_starved" : "ctrl_starved", wcnt[x], x == 2 ? MVU_BOUND : CTRL_BOUND);
        end
      end
    end
  end

  task automatic wait_gnt(input int x);
    int n = 0;
    while (!d_gnt[x] && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (!d_gnt[x]) chk($sformatf("gnt_timeout_%0d", x), d_gnt, 3'(1 << (x - 1)));
  endtask

  task automatic rand_drive();
    int prob [1:3] = '{30, 50, 50};
    rst = ($urandom_range(0, 1999) == 0);
    for (int x = 1; x <= 3; x++) begin
      if (!t_req[x] || served[x]) begin
        served[x] = 0;
        if ($urandom_range(0, 99) < prob[x]) begin
          t_req[x]  = 1'b1;
          t_we[x]   = 1'($urandom_range(0, 1));
          t_lock[x] = 1'($urandom_range(0, 1));
          t_addr[x] = A'($urandom_range(0, 15));
          t_wd[x]   = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          t_req[x]  = 1'b0;
          t_lock[x] = 1'b0;
        end
      end
      if (t_req[x] && d_gnt[x]) begin
        if ($urandom_range(0, 31) == 0) t_req[x] = 1'b0;
        else served[x] = 1;
      end
    end
  endtask

  initial begin : directed
    rst = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    for (int x = 1; x <= 3; x++) begin
      t_req[x] = 1'b1; t_lock[x] = 1'b0; t_we[x] = 1'b0;
      t_addr[x] = '0;  t_wd[x] = '0;     served[x] = 0;
    end

    // Reset with all requests asserted, then plain priority/aging sequence
    @(posedge clk); #2;
    chk("rst_gnt", d_gnt, 0);
    chk("rst_rvalid", d_rv, 0);
    chk("rst_we", bus.bram_we, 0);
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("c0_gnt", d_gnt, 0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #2;
      chk($sformatf("seq_gnt_c%0d", c), d_gnt, (c <= 8) ? 3'b001 : (c == 9) ? 3'b010 : 3'b100);
      if (c == 2) chk("seq_rvalid_c2", d_rv, 3'b001);
    end

    // MVU write, then Ctrl read-back
    @(posedge clk); #1;
    t_req[1] = 0; t_req[3] = 0;
    t_req[2] = 1; t_we[2] = 1; t_addr[2] = 9'h1A5; t_wd[2] = DATA;
    wait_gnt(2); #1;
    chk("wr_we", bus.bram_we, 1);
    chk("wr_addr", bus.bram_addr, 9'h1A5);
    chk("wr_data", bus.bram_wdata, DATA);
    @(posedge clk); #1;
    t_req[2] = 0; t_we[2] = 0;
    t_req[3] = 1; t_we[3] = 0; t_addr[3] = 9'h1A5;
    wait_gnt(3);
    @(posedge clk); #1;
    t_req[3] = 0; #1;
    chk("rd_rvalid", d_rv, 3'b100);
    chk("rd_data", bus.rdata, DATA);

    // Locked MVU burst, IC waits, IC withdraws in its grant cycle, reset mid-burst
    @(posedge clk); #1;
    for (int x = 1; x <= 3; x++) t_req[x] = 0;
    @(posedge clk);
    @(posedge clk); #1;
    t_req[2] = 1; t_lock[2] = 1; t_we[2] = 0; t_addr[2] = 9'h010;
    t_we[1] = 1; t_addr[1] = 9'h020; t_wd[1] = {4{32'h5A5A_A5A5}};
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 2) t_req[1] = 1;
      if (c == 5) t_req[1] = 0;
      #1;
      chk($sformatf("burst_gnt_c%0d", c), d_gnt, (c == 5) ? 3'b001 : 3'b010);
      if (c == 5) chk("withdraw_we", bus.bram_we, 0);
      if (c == 6) chk("withdraw_rvalid", d_rv, 0);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("midrst_gnt", d_gnt, 0);
    chk("midrst_rvalid", d_rv, 0);
    chk("midrst_ctrs", {dut.burst_q, dut.wait_mvu_q, dut.wait_ctrl_q}, 0);

    // Random three-port traffic
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #1;
      rand_drive();
    end
    @(posedge clk); #2;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
